// File: rtl/mag_tx_scheduler.sv
// rtl/mag_tx_scheduler.sv - frames two magnitude bins into an 8-byte UART packet
//
// Purpose:
//   Captures a qualified magnitude sample (G0, G1, current_run) and sends it
//   to a byte-wide UART as the frame
//     SYNC, {3'b000,run}, G0 hi, G0 lo, G1 hi, G1 lo, CHK, TERM
//   where CHK is the XOR of the run byte through G1 lo. Strobes that arrive
//   while a frame is in flight are discarded and counted.
//
// Ports:
//   sys_clk       in   single clock, rising edge
//   rst_n         in   synchronous active-low reset
//   G0, G1        in   16-bit magnitudes, bins 0 and 1
//   G_READY       in   one-cycle strobe qualifying G0/G1/current_run
//   current_run   in   5-bit run index
//   TX_LOAD_OKAY  in   UART ready for a byte (drops once it has taken one)
//   TX_DATA       out  byte to the UART, held between loads
//   TX_LOAD       out  one-cycle load strobe to the UART
//   busy          out  high while a frame is in flight
//   frame_done    out  one-cycle pulse after the final byte is accepted
//   drop_cnt      out  saturating count of discarded qualified strobes
module mag_tx_scheduler #(
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter logic [7:0] TERM_BYTE  = 8'h0A,
  parameter int         RUN_FILTER = 1,
  parameter logic [4:0] RUN_SEL    = 5'd3
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [15:0] G0,
  input  logic [15:0] G1,
  input  logic        G_READY,
  input  logic [4:0]  current_run,
  input  logic        TX_LOAD_OKAY,
  output logic [7:0]  TX_DATA,
  output logic        TX_LOAD,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACK_WAIT,
    ST_READY_WAIT
  } state_t;

  localparam logic [3:0] ACK_TIMEOUT_LAST = 4'd15;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  tmo_q, tmo_d;
  logic [15:0] g0_q, g0_d;
  logic [15:0] g1_q, g1_d;
  logic [4:0]  run_q, run_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_load_q, tx_load_d;
  logic        done_q, done_d;
  logic [7:0]  drop_q, drop_d;

  logic        qualified;
  logic        accept;
  logic        drop;
  logic [7:0]  run_byte;
  logic [7:0]  chk_byte;
  logic [7:0]  cur_byte;

  assign qualified = G_READY && ((RUN_FILTER == 0) || (current_run == RUN_SEL));
  // The frame_done cycle is still treated as busy so a strobe landing on it
  // is counted as dropped rather than starting a new frame.
  assign accept    = qualified && (state_q == ST_IDLE) && !done_q;
  assign drop      = qualified && !accept;

  assign run_byte  = {3'b000, run_q};
  assign chk_byte  = run_byte ^ g0_q[15:8] ^ g0_q[7:0] ^ g1_q[15:8] ^ g1_q[7:0];

  always_comb begin
    cur_byte = SYNC_BYTE;
    case (idx_q)
      3'd0:    cur_byte = SYNC_BYTE;
      3'd1:    cur_byte = run_byte;
      3'd2:    cur_byte = g0_q[15:8];
      3'd3:    cur_byte = g0_q[7:0];
      3'd4:    cur_byte = g1_q[15:8];
      3'd5:    cur_byte = g1_q[7:0];
      3'd6:    cur_byte = chk_byte;
      default: cur_byte = TERM_BYTE;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    g0_d      = g0_q;
    g1_d      = g1_q;
    run_d     = run_q;
    tx_data_d = tx_data_q;
    tx_load_d = 1'b0;
    done_d    = 1'b0;
    drop_d    = drop_q;

    if (drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        idx_d = 3'd0;
        if (accept) begin
          g0_d    = G0;
          g1_d    = G1;
          run_d   = current_run;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (TX_LOAD_OKAY) begin
          tx_data_d = cur_byte;
          tx_load_d = 1'b1;
          tmo_d     = 4'd0;
          state_d   = ST_ACK_WAIT;
        end
      end

      // The load cycle itself is the first of the 16 cycles counted here;
      // a UART that never drops OKAY is assumed to have taken the byte.
      ST_ACK_WAIT: begin
        if (!TX_LOAD_OKAY) begin
          state_d = ST_READY_WAIT;
        end else if (tmo_q == ACK_TIMEOUT_LAST) begin
          state_d = ST_READY_WAIT;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end

      ST_READY_WAIT: begin
        if (TX_LOAD_OKAY) begin
          if (idx_q == 3'd7) begin
            idx_d   = 3'd0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_LOAD;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= 3'd0;
      tmo_q     <= 4'd0;
      g0_q      <= 16'h0000;
      g1_q      <= 16'h0000;
      run_q     <= 5'd0;
      tx_data_q <= 8'h00;
      tx_load_q <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      g0_q      <= g0_d;
      g1_q      <= g1_d;
      run_q     <= run_d;
      tx_data_q <= tx_data_d;
      tx_load_q <= tx_load_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  assign TX_DATA    = tx_data_q;
  assign TX_LOAD    = tx_load_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = done_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_mag_tx_scheduler.sv
// tb/tb_mag_tx_scheduler.sv - directed self-checking bench for mag_tx_scheduler
module tb_mag_tx_scheduler;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic [15:0] G0, G1;
  logic        G_READY;
  logic [4:0]  current_run;
  logic        TX_LOAD_OKAY;
  logic [7:0]  TX_DATA;
  logic        TX_LOAD;
  logic        busy;
  logic        frame_done;
  logic [7:0]  drop_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  mag_tx_scheduler dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .G0           (G0),
    .G1           (G1),
    .G_READY      (G_READY),
    .current_run  (current_run),
    .TX_LOAD_OKAY (TX_LOAD_OKAY),
    .TX_DATA      (TX_DATA),
    .TX_LOAD      (TX_LOAD),
    .busy         (busy),
    .frame_done   (frame_done),
    .drop_cnt     (drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // UART model: OKAY drops the cycle after a load and returns 10 cycles later,
  // unless never_drop is set; block forces OKAY low.
  int   ucnt = 0;
  logic uart_never_drop = 1'b0;
  logic uart_block = 1'b0;
  always @(posedge sys_clk) begin
    if (TX_LOAD && !uart_never_drop) ucnt <= 10;
    else if (ucnt != 0)              ucnt <= ucnt - 1;
  end
  assign TX_LOAD_OKAY = (ucnt == 0) && !uart_block;

  // Byte monitor
  int         cyc = 0;
  int         load_n = 0;
  int         done_n = 0;
  int         b2b_n = 0;
  logic       prev_load = 1'b0;
  logic [7:0] load_d [512];
  int         load_t [512];
  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(negedge sys_clk) begin
    if (TX_LOAD) begin
      if (load_n < 512) begin
        load_d[load_n] = TX_DATA;
        load_t[load_n] = cyc;
      end
      load_n = load_n + 1;
      if (prev_load) b2b_n = b2b_n + 1;
    end
    prev_load = TX_LOAD;
    if (frame_done) done_n = done_n + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i, input logic [15:0] g0, input logic [15:0] g1,
                                          input logic [4:0] run);
    logic [7:0] rb;
    rb = {3'b000, run};
    case (i)
      0: return 8'hA5;
      1: return rb;
      2: return g0[15:8];
      3: return g0[7:0];
      4: return g1[15:8];
      5: return g1[7:0];
      6: return rb ^ g0[15:8] ^ g0[7:0] ^ g1[15:8] ^ g1[7:0];
      default: return 8'h0A;
    endcase
  endfunction

  // Drive a one-cycle strobe starting at the current negedge.
  task automatic send(input logic [15:0] g0, input logic [15:0] g1, input logic [4:0] run);
    G0 = g0; G1 = g1; current_run = run; G_READY = 1'b1;
    @(negedge sys_clk);
    G_READY = 1'b0;
  endtask

  // Strobe and check the 2-cycle latency to the SYNC byte; returns load base index.
  task automatic start_frame(input string tag, input logic [15:0] g0, input logic [15:0] g1,
                             input logic [4:0] run, output int base);
    base = load_n;
    send(g0, g1, run);
    chk({tag, " busy+1"}, busy, 1'b1);
    chk({tag, " noload+1"}, TX_LOAD, 1'b0);
    @(negedge sys_clk);
    chk({tag, " load+2"}, TX_LOAD, 1'b1);
    chk({tag, " sync"}, TX_DATA, 8'hA5);
  endtask

  task automatic wait_loads(input string tag, input int have, input int target);
    int k;
    int g;
    k = have;
    g = 0;
    while (k < target && g < 500) begin
      @(negedge sys_clk);
      g++;
      if (TX_LOAD) k++;
    end
    chk({tag, " reach load"}, k, target);
  endtask

  task automatic wait_done(input string tag);
    int g;
    g = 0;
    while (!frame_done && g < 2000) begin
      @(negedge sys_clk);
      g++;
    end
    chk({tag, " frame_done"}, frame_done, 1'b1);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [15:0] g0,
                             input logic [15:0] g1, input logic [4:0] run);
    chk({tag, " nloads"}, load_n - base, 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s byte%0d", tag, i), load_d[base + i], exp_byte(i, g0, g1, run));
  endtask

  logic [7:0] lit [8];
  int base, d0, k, g;

  initial begin
    rst_n = 1'b0; G0 = 16'h0; G1 = 16'h0; G_READY = 1'b0; current_run = 5'd0;
    repeat (3) @(negedge sys_clk);
    chk("rst TX_DATA", TX_DATA, 8'h00);
    chk("rst TX_LOAD", TX_LOAD, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst frame_done", frame_done, 1'b0);
    chk("rst drop_cnt", drop_cnt, 8'h00);
    rst_n = 1'b1;
    @(negedge sys_clk);

    // Basic frame against hand-computed bytes
    lit = '{8'hA5, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43, 8'h0A};
    d0 = done_n;
    start_frame("f1", 16'h1234, 16'hABCD, 5'd3, base);
    wait_done("f1");
    chk("f1 busy at done", busy, 1'b0);
    @(negedge sys_clk);
    chk("f1 done pulse len", frame_done, 1'b0);
    chk("f1 done count", done_n - d0, 1);
    chk("f1 nloads", load_n - base, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("f1 lit byte%0d", i), load_d[base + i], lit[i]);
    chk("f1 gap", load_t[base + 1] - load_t[base], 13);

    // Run filter
    k = 0;
    send(16'h1111, 16'h2222, 5'd0); if (TX_LOAD) k++;
    send(16'h1111, 16'h2222, 5'd1); if (TX_LOAD) k++;
    send(16'h1111, 16'h2222, 5'd2); if (TX_LOAD) k++;
    repeat (20) begin @(negedge sys_clk); if (TX_LOAD) k++; end
    chk("filter no loads", k, 0);
    chk("filter busy", busy, 1'b0);
    chk("filter drop_cnt", drop_cnt, 8'h00);
    start_frame("f2", 16'h0F0F, 16'h00FF, 5'd3, base);
    wait_done("f2");
    @(negedge sys_clk);
    check_frame("f2", base, 16'h0F0F, 16'h00FF, 5'd3);

    // Strobe during byte 4 must not disturb the snapshot
    start_frame("f3", 16'hBEEF, 16'h5A5A, 5'd3, base);
    wait_loads("f3", 1, 4);
    send(16'h7777, 16'h8888, 5'd3);
    chk("f3 drop_cnt", drop_cnt, 8'h01);
    wait_done("f3");
    @(negedge sys_clk);
    check_frame("f3", base, 16'hBEEF, 16'h5A5A, 5'd3);

    // Strobe on the frame_done cycle is dropped
    start_frame("f4", 16'h0001, 16'h8000, 5'd3, base);
    wait_done("f4");
    send(16'h4444, 16'h5555, 5'd3);
    chk("f4 done-cycle busy", busy, 1'b0);
    chk("f4 done-cycle drop", drop_cnt, 8'h02);
    k = 0;
    repeat (5) begin @(negedge sys_clk); if (TX_LOAD || busy) k++; end
    chk("f4 no restart", k, 0);
    check_frame("f4", base, 16'h0001, 16'h8000, 5'd3);

    // Saturation: 300 cycles of qualified strobes
    G0 = 16'hCAFE; G1 = 16'hF00D; current_run = 5'd3; G_READY = 1'b1;
    repeat (300) @(negedge sys_clk);
    G_READY = 1'b0;
    g = 0;
    while (busy && g < 2000) begin @(negedge sys_clk); g++; end
    chk("sat idle", busy, 1'b0);
    chk("sat drop_cnt", drop_cnt, 8'hFF);
    repeat (3) @(negedge sys_clk);

    // OKAY held low while in LOAD for byte 2
    start_frame("f5", 16'h9876, 16'h0420, 5'd3, base);
    wait_loads("f5", 1, 2);
    g = 0;
    while (!TX_LOAD_OKAY && g < 50) begin @(negedge sys_clk); g++; end
    chk("f5 okay back", TX_LOAD_OKAY, 1'b1);
    @(negedge sys_clk);
    uart_block = 1'b1;
    k = 0;
    repeat (50) begin @(negedge sys_clk); if (TX_LOAD) k++; end
    chk("f5 stall loads", k, 0);
    chk("f5 stall busy", busy, 1'b1);
    uart_block = 1'b0;
    wait_done("f5");
    @(negedge sys_clk);
    check_frame("f5", base, 16'h9876, 16'h0420, 5'd3);

    // UART never drops OKAY: per-byte acceptance by timeout
    uart_never_drop = 1'b1;
    d0 = done_n;
    start_frame("f6", 16'h5555, 16'hAAAA, 5'd3, base);
    wait_done("f6");
    @(negedge sys_clk);
    check_frame("f6", base, 16'h5555, 16'hAAAA, 5'd3);
    chk("f6 timeout gap", load_t[base + 1] - load_t[base], 18);
    chk("f6 done count", done_n - d0, 1);
    uart_never_drop = 1'b0;

    // Reset during byte 5
    start_frame("f7", 16'h3C3C, 16'hC3C3, 5'd3, base);
    wait_loads("f7", 1, 5);
    rst_n = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b1;
    chk("mid-rst TX_DATA", TX_DATA, 8'h00);
    chk("mid-rst TX_LOAD", TX_LOAD, 1'b0);
    chk("mid-rst busy", busy, 1'b0);
    chk("mid-rst frame_done", frame_done, 1'b0);
    chk("mid-rst drop_cnt", drop_cnt, 8'h00);
    d0 = done_n;
    k = 0;
    repeat (40) begin @(negedge sys_clk); if (TX_LOAD || busy) k++; end
    chk("post-rst quiet", k, 0);
    chk("post-rst no done", done_n - d0, 0);
    start_frame("f8", 16'h0102, 16'h0304, 5'd3, base);
    wait_done("f8");
    @(negedge sys_clk);
    check_frame("f8", base, 16'h0102, 16'h0304, 5'd3);

    chk("no back-to-back TX_LOAD", b2b_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
